// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and the decode hazard unit.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   regaddr_t           : register address for the 32-register configuration
//   ZERO_REG            : hard-wired zero register index
//   prio_onehot()       : keeps only the highest set request bit (highest write port wins)
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned MAX_PORTS = 32;

    typedef logic [4:0] regaddr_t;

    localparam regaddr_t ZERO_REG = 5'd0;

    // Highest-index request wins; later loop iterations overwrite earlier grants.
    function automatic logic [MAX_PORTS-1:0] prio_onehot(input logic [MAX_PORTS-1:0] req);
        logic [MAX_PORTS-1:0] gnt;
        gnt = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst_n         : clock, async active-low reset
//   wr_en/wr_addr      : writeback ports, clear busy on the target register
//   rsv_en/rsv_addr    : destination reservation, sets busy (beats a same-cycle write)
//   flush              : clears every busy bit and suppresses a same-cycle reservation
//   busy               : busy vector (bit 0 always 0)
//   busy_cnt           : registered popcount of busy
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NWR  = 2,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR-1:0][AW-1:0]  wr_addr,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr,
    input  logic                    flush,
    output logic [NREG-1:0]         busy,
    output logic [AW:0]             busy_cnt
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            clr;

    // Addresses >= NREG never match any loop index, so they fall out naturally.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        clr    = 1'b0;
        for (int a = 1; a < NREG; a++) begin
            clr = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                clr = clr | (wr_en[k] && (wr_addr[k] == AW'(a)));
            end
            if (flush) begin
                busy_d[a] = 1'b0;
            end else if (rsv_en && (rsv_addr == AW'(a))) begin
                busy_d[a] = 1'b1;
            end else if (clr) begin
                busy_d[a] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
        for (int a = 0; a < NREG; a++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[a]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
//   clk, rst_n            : clock, async active-low reset (clears storage and busy)
//   rd_addr -> rd_data    : NRD combinational read ports
//   rd_busy               : register has a pending write not satisfied this cycle
//   wr_en/wr_addr/wr_data : NWR write ports, highest index wins on conflicts
//   rsv_en/rsv_addr       : reserve a destination
//   flush                 : clear all busy bits, keep contents
//   busy_cnt              : number of busy registers (registered)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned AW     = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     flush,
    output logic [AW:0]              busy_cnt
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [NWR-1:0]  wr_ok;
    logic [NREG-1:0] busy;
    logic [NWR-1:0]  req, gnt;
    logic [XLEN-1:0] byp;

    // Non-zero and inside the implemented register range.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != AW'(ZERO_REG)) && (32'(a) < NREG);
    endfunction

    always_comb begin
        for (int k = 0; k < NWR; k++) begin
            wr_ok[k] = wr_en[k] && addr_ok(wr_addr[k]);
        end
    end

    // Ascending port order: the last (highest) enabled port's assignment sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_ok[k]) begin
                    mem_q[wr_addr[k]] <= wr_data[k];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        req     = '0;
        gnt     = '0;
        byp     = '0;
        for (int p = 0; p < NRD; p++) begin
            // wr_ok already excludes X0 and out-of-range, so a match implies a valid rd_addr.
            for (int k = 0; k < NWR; k++) begin
                req[k] = wr_ok[k] && (wr_addr[k] == rd_addr[p]);
            end
            gnt = NWR'(prio_onehot(MAX_PORTS'(req)));
            byp = '0;
            for (int k = 0; k < NWR; k++) begin
                byp = byp | ({XLEN{gnt[k]}} & wr_data[k]);
            end
            if (addr_ok(rd_addr[p])) begin
                if (BYPASS && (req != '0)) begin
                    rd_data[p] = byp;
                end else begin
                    rd_data[p] = mem_q[rd_addr[p]];
                end
                rd_busy[p] = busy[rd_addr[p]] && !(BYPASS && (req != '0));
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: instance A (NREG=32, BYPASS=1) and instance B (NREG=24, BYPASS=0)
// share all inputs; a queue of expected outputs is filled by the driver and drained by a monitor.
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [NRD-1:0][AW-1:0]   rd_addr  = '0;
    logic [NWR-1:0]           wr_en    = '0;
    logic [NWR-1:0][AW-1:0]   wr_addr  = '0;
    logic [NWR-1:0][XLEN-1:0] wr_data  = '0;
    logic                     rsv_en   = 1'b0;
    logic [AW-1:0]            rsv_addr = '0;
    logic                     flush    = 1'b0;

    logic [NRD-1:0][XLEN-1:0] rd_data_a, rd_data_b;
    logic [NRD-1:0]           rd_busy_a, rd_busy_b;
    logic [AW:0]              busy_cnt_a, busy_cnt_b;

    regfile_mp #(
        .XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(busy_cnt_a)
    );

    regfile_mp #(
        .XLEN(64), .NREG(24), .NRD(2), .NWR(2), .BYPASS(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(busy_cnt_b)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays per instance.
    logic [63:0] m_reg  [2][32];
    bit          m_busy [2][32];
    int          m_nreg [2] = '{32, 24};
    bit          m_byp  [2] = '{1'b1, 1'b0};

    typedef struct packed {
        logic [1:0][1:0][63:0] d;   // [inst][port]
        logic [1:0][1:0]       b;
        logic [1:0][5:0]       c;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 32; a++) begin
                m_reg[i][a]  = '0;
                m_busy[i][a] = 1'b0;
            end
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e = '0;
        for (int i = 0; i < 2; i++) begin
            int cnt;
            cnt = 0;
            for (int a = 0; a < 32; a++) if (m_busy[i][a]) cnt++;
            e.c[i] = 6'(cnt);
            for (int p = 0; p < 2; p++) begin
                int a;
                int win;
                a   = int'(rd_addr[p]);
                win = -1;
                if (a != 0 && a < m_nreg[i]) begin
                    for (int k = 0; k < 2; k++) begin
                        if (wr_en[k] && int'(wr_addr[k]) == a) win = k;
                    end
                    if (m_byp[i] && win >= 0) begin
                        e.d[i][p] = wr_data[win];
                        e.b[i][p] = 1'b0;
                    end else begin
                        e.d[i][p] = m_reg[i][a];
                        e.b[i][p] = m_busy[i][a];
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int a;
            for (int k = 0; k < 2; k++) begin
                a = int'(wr_addr[k]);
                if (wr_en[k] && a != 0 && a < m_nreg[i]) begin
                    m_reg[i][a]  = wr_data[k];
                    m_busy[i][a] = 1'b0;
                end
            end
            a = int'(rsv_addr);
            if (rsv_en && !flush && a != 0 && a < m_nreg[i]) m_busy[i][a] = 1'b1;
            if (flush) for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
        end
    endtask

    task automatic cyc(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] we,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic rv, input logic [4:0] ra, input logic fl);
        @(negedge clk);
        rd_addr[0] = r0;  rd_addr[1] = r1;
        wr_en      = we;
        wr_addr[0] = a0;  wr_addr[1] = a1;
        wr_data[0] = d0;  wr_data[1] = d1;
        rsv_en     = rv;  rsv_addr   = ra;
        flush      = fl;
        q.push_back(predict());
        if (rst_n) model_step();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, well before the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("a_rd_data%0d", p), rd_data_a[p], e.d[0][p]);
                    chk($sformatf("b_rd_data%0d", p), rd_data_b[p], e.d[1][p]);
                    chk($sformatf("a_rd_busy%0d", p), 64'(rd_busy_a[p]), 64'(e.b[0][p]));
                    chk($sformatf("b_rd_busy%0d", p), 64'(rd_busy_b[p]), 64'(e.b[1][p]));
                end
                chk("a_busy_cnt", 64'(busy_cnt_a), 64'(e.c[0]));
                chk("b_busy_cnt", 64'(busy_cnt_b), 64'(e.c[1]));
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state across every address.
        for (int j = 0; j < 16; j++) begin
            cyc(5'(2*j), 5'(2*j+1), 2'b00, 0, 0, 0, 0, 0, 0, 0);
        end

        // Same-cycle bypass vs stored value, then both see it.
        cyc(5, 5, 2'b01, 5, 0, 64'hDEAD_BEEF, 0, 0, 0, 0);
        cyc(5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        // Port conflict: port 1 wins.
        cyc(7, 7, 2'b11, 7, 7, 64'h11, 64'h22, 0, 0, 0);
        cyc(7, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        // X0 is never written.
        cyc(0, 0, 2'b01, 0, 0, 64'hFFFF, 0, 0, 0, 0);
        cyc(0, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        // Reserve X9, then retire it.
        cyc(9, 0, 2'b00, 0, 0, 0, 0, 1, 9, 0);
        cyc(9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc(9, 9, 2'b01, 9, 0, 64'h42, 0, 0, 0, 0);
        cyc(9, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        // Reservation beats same-cycle write.
        cyc(3, 0, 2'b01, 3, 0, 64'h33, 0, 1, 3, 0);
        cyc(3, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        // Flush wipes busy and drops a same-cycle reservation.
        cyc(1, 2, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 2, 2'b00, 0, 0, 0, 0, 1, 2, 0);
        cyc(4, 1, 2'b00, 0, 0, 0, 0, 1, 4, 0);
        cyc(1, 2, 2'b00, 0, 0, 0, 0, 1, 6, 1);
        cyc(4, 6, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        // Address 30: real register in A, out of range in B.
        cyc(30, 30, 2'b01, 30, 0, 64'h3030, 0, 1, 30, 0);
        cyc(30, 29, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        // Double reservation then a single write clears it.
        cyc(10, 0, 2'b00, 0, 0, 0, 0, 1, 10, 0);
        cyc(10, 0, 2'b00, 0, 0, 0, 0, 1, 10, 0);
        cyc(10, 0, 2'b10, 0, 10, 0, 64'h1010, 0, 0, 0);
        cyc(10, 0, 2'b00, 0, 0, 0, 0, 1, 11, 0);
        cyc(11, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // Async reset mid-cycle: outputs must clear before the next edge.
        @(negedge clk);
        #1;
        wr_en = '0; rsv_en = 1'b0; flush = 1'b0;
        rd_addr[0] = 7; rd_addr[1] = 11;
        rst_n = 1'b0;
        model_reset();
        q.push_back(predict());
        @(negedge clk);
        rst_n = 1'b1;
        cyc(7, 11, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cyc(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                {$urandom, $urandom}, {$urandom, $urandom},
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                ($urandom_range(0, 19) == 0));
        end

        repeat (2) @(negedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got=%0d pending want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
